mat_job_initiator: RTL

MAT_JOB_INITIATOR -- requirements
Module: mat_job_initiator

---
 rtl/mat_job_initiator.sv | 83 ++++++++
 1 files changed

// File: rtl/mat_job_initiator.sv
// mat_job_initiator: hands one 2x2 matrix job at a time to an accelerator, with a timeout,
// and queues the results or timeout markers in a 2-entry buffer.
module mat_job_initiator #(
    parameter int WIDTH      = 8,
    parameter int TIMEOUT    = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [4*WIDTH-1:0] job_data,
    output logic [4*WIDTH-1:0] acc_A,
    output logic               acc_start,
    input  logic               acc_done,
    output logic               acc_done_ack,
    input  logic [63:0]        acc_res,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [63:0]        res_data,
    output logic               res_err,
    output logic [7:0]         err_cnt,
    output logic [1:0]         state
);
    localparam logic [1:0] IDLE = 2'b00, ISSUE = 2'b01, WAIT = 2'b10, ACK = 2'b11;
    logic [1:0]  st;
    logic [5:0]  timer;
    logic [1:0]  count;
    logic        rd_ptr, wr_ptr, push, pop;
    logic [64:0] push_val;
    logic [64:0] mem [2];
    // done wins over the timeout when both land on the same cycle
    always_comb begin
        push         = st == WAIT && (acc_done || timer == 6'(TIMEOUT - 1));
        push_val     = acc_done ? {1'b0, acc_res} : {1'b1, 64'h0};
        job_ready    = reset && st == IDLE && count < 2'(FIFO_DEPTH);
        acc_start    = reset && st == ISSUE;
        acc_done_ack = reset && st == ACK;
        res_valid    = reset && count != 2'd0;
        res_data     = res_valid ? mem[rd_ptr][63:0] : 64'h0;
        res_err      = res_valid && mem[rd_ptr][64];
        state        = reset ? st : IDLE;
        pop          = res_valid && res_ready;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            st      <= IDLE;
            timer   <= 6'd0;
            count   <= 2'd0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            err_cnt <= 8'd0;
            acc_A   <= '0;
        end else begin
            if (st == IDLE && job_valid && job_ready) begin
                acc_A <= job_data;
                st    <= ISSUE;
            end
            if (st == ISSUE) begin
                st    <= WAIT;
                timer <= 6'd0;
            end
            if (st == WAIT) begin
                timer <= timer + 6'd1;
                if (acc_done)
                    st <= ACK;
                else if (push) begin
                    st      <= IDLE;
                    err_cnt <= err_cnt + {7'd0, err_cnt != 8'hff};
                end
            end
            if (st == ACK && !acc_done)
                st <= IDLE;
            if (push) begin
                mem[wr_ptr] <= push_val;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule
